// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one MMU port between CPU (A) and DMA (B), with B starvation guard and bounded lock bursts.
module mem_arbiter #(
  parameter int MAX_WAIT = 4,
  parameter int LOCK_MAX = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        a_req,
  input  logic        a_we,
  input  logic [15:0] a_addr,
  input  logic [15:0] a_wdata,
  output logic        a_gnt,
  output logic [15:0] a_rdata,
  output logic        a_rvalid,
  input  logic        b_req,
  input  logic        b_we,
  input  logic [15:0] b_addr,
  input  logic [15:0] b_wdata,
  input  logic        b_lock,
  output logic        b_gnt,
  output logic [15:0] b_rdata,
  output logic        b_rvalid,
  output logic        mmu_w_en,
  output logic [15:0] mmu_addr,
  output logic [15:0] mmu_data_w,
  input  logic [15:0] mmu_data_r
);
  localparam int WW = $clog2(MAX_WAIT + 1);
  localparam int LW = $clog2(LOCK_MAX + 1);
  logic [WW-1:0] wait_q, wait_d;
  logic [LW-1:0] lock_q, lock_d;
  logic          locked_q, locked_d, norelock_q, norelock_d;
  logic          a_rv_q, a_rv_d, b_rv_q, b_rv_d;
  logic [15:0]   a_rd_q, a_rd_d, b_rd_q, b_rd_d;
  logic          b_win, lock_inc, forced;
  always_comb begin
    b_win      = b_req & (locked_q | !a_req | (wait_q >= WW'(MAX_WAIT)));
    b_gnt      = !rst & b_win;
    a_gnt      = !rst & a_req & !b_win;
    mmu_addr   = b_gnt ? b_addr : a_gnt ? a_addr : 16'h0;
    mmu_data_w = b_gnt ? b_wdata : a_gnt ? a_wdata : 16'h0;
    mmu_w_en   = (a_gnt & a_we) | (b_gnt & b_we);
    wait_d     = (b_req & !b_gnt) ? ((wait_q == WW'(MAX_WAIT)) ? wait_q : wait_q + WW'(1)) : '0;
    // lock_q is zero whenever unlocked, so lock_q+1 covers both the first grant and increments
    lock_inc   = b_gnt & b_lock & (locked_q | !norelock_q);
    forced     = lock_inc & (lock_q + LW'(1) == LW'(LOCK_MAX));
    locked_d   = lock_inc & !forced;
    lock_d     = locked_d ? lock_q + LW'(1) : '0;
    norelock_d = forced | (norelock_q & b_gnt);
    a_rv_d     = a_gnt & !a_we;
    b_rv_d     = b_gnt & !b_we;
    a_rd_d     = a_rv_d ? mmu_data_r : a_rd_q;
    b_rd_d     = b_rv_d ? mmu_data_r : b_rd_q;
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wait_q     <= '0;
      lock_q     <= '0;
      locked_q   <= 1'b0;
      norelock_q <= 1'b0;
      a_rv_q     <= 1'b0;
      b_rv_q     <= 1'b0;
      a_rd_q     <= 16'h0;
      b_rd_q     <= 16'h0;
    end else begin
      wait_q     <= wait_d;
      lock_q     <= lock_d;
      locked_q   <= locked_d;
      norelock_q <= norelock_d;
      a_rv_q     <= a_rv_d;
      b_rv_q     <= b_rv_d;
      a_rd_q     <= a_rd_d;
      b_rd_q     <= b_rd_d;
    end
  end
  assign a_rvalid = a_rv_q;
  assign b_rvalid = b_rv_q;
  assign a_rdata  = a_rd_q;
  assign b_rdata  = b_rd_q;
endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: directed and random checks of mem_arbiter against a cycle-level reference model.
module tb_mem_arbiter;
  localparam int MW = 4;
  localparam int LM = 16;
  logic clk = 1'b0, rst = 1'b1, clr = 1'b1;
  logic a_req = 0, a_we = 0, b_req = 0, b_we = 0, b_lock = 0;
  logic [15:0] a_addr = 0, a_wdata = 0, b_addr = 0, b_wdata = 0;
  logic a_gnt, a_rvalid, b_gnt, b_rvalid, mmu_w_en;
  logic [15:0] a_rdata, b_rdata, mmu_addr, mmu_data_w, mmu_data_r;
  always #5 clk = ~clk;
  mem_arbiter #(.MAX_WAIT(MW), .LOCK_MAX(LM)) dut (
    .clk(clk), .rst(rst),
    .a_req(a_req), .a_we(a_we), .a_addr(a_addr), .a_wdata(a_wdata),
    .a_gnt(a_gnt), .a_rdata(a_rdata), .a_rvalid(a_rvalid),
    .b_req(b_req), .b_we(b_we), .b_addr(b_addr), .b_wdata(b_wdata), .b_lock(b_lock),
    .b_gnt(b_gnt), .b_rdata(b_rdata), .b_rvalid(b_rvalid),
    .mmu_w_en(mmu_w_en), .mmu_addr(mmu_addr), .mmu_data_w(mmu_data_w), .mmu_data_r(mmu_data_r)
  );
  function automatic logic [5:0] ix(logic [15:0] a);
    return {a[15], a[4:0]};
  endfunction
  function automatic logic [15:0] iv(logic [5:0] i);
    return 16'h5a00 | 16'(i);
  endfunction
  function automatic logic [15:0] rnd_addr();
    return {1'($urandom), 10'b0, 5'($urandom)};
  endfunction
  // MMU stub: ROM half ignores writes, unwritten cells read a fixed pattern
  logic [15:0] mem [64];
  logic [63:0] wv;
  assign mmu_data_r = wv[ix(mmu_addr)] ? mem[ix(mmu_addr)] : iv(ix(mmu_addr));
  always @(posedge clk)
    if (clr) wv <= '0;
    else if (mmu_w_en && mmu_addr[15]) begin
      mem[ix(mmu_addr)] <= mmu_data_w;
      wv[ix(mmu_addr)]  <= 1'b1;
    end
  int checks = 0, failures = 0;
  int m_wait, m_lcnt, own;
  bit m_locked, m_nore, e_av, e_bv;
  logic [15:0] e_ad, e_bd;
  logic [15:0] rm [64];
  logic obs_a, obs_b, obs_av, obs_bv, obs_we;
  logic [15:0] obs_ad, obs_bd;
  task automatic check(input string tag, input int got, input int exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h expected=%0h t=%0t", tag, got, exp, $time);
    end
  endtask
  task automatic cycle();
    bit bg, forced;
    logic [15:0] ea, ed;
    @(negedge clk);
    if (rst) begin
      m_wait = 0; m_lcnt = 0; m_locked = 0; m_nore = 0;
      e_av = 0; e_bv = 0; e_ad = 0; e_bd = 0;
    end
    if (rst) own = 0;
    else if (m_locked && b_req) own = 2;
    else if (a_req && b_req) own = (m_wait >= MW) ? 2 : 1;
    else own = a_req ? 1 : b_req ? 2 : 0;
    ea = own == 1 ? a_addr : own == 2 ? b_addr : 16'h0;
    ed = own == 1 ? a_wdata : own == 2 ? b_wdata : 16'h0;
    obs_a = a_gnt; obs_b = b_gnt; obs_av = a_rvalid; obs_bv = b_rvalid;
    obs_ad = a_rdata; obs_bd = b_rdata; obs_we = mmu_w_en;
    check("a_gnt", a_gnt, int'(own == 1));
    check("b_gnt", b_gnt, int'(own == 2));
    check("mmu_addr", mmu_addr, ea);
    check("mmu_data_w", mmu_data_w, ed);
    check("mmu_w_en", mmu_w_en, int'((own == 1 && a_we) || (own == 2 && b_we)));
    check("a_rvalid", a_rvalid, e_av);
    check("b_rvalid", b_rvalid, e_bv);
    check("a_rdata", a_rdata, e_ad);
    check("b_rdata", b_rdata, e_bd);
    @(posedge clk);
    if (!rst) begin
      bg = own == 2;
      forced = 0;
      m_wait = (b_req && !bg) ? ((m_wait + 1 > MW) ? MW : m_wait + 1) : 0;
      if (m_locked) begin
        if (bg && b_lock && m_lcnt + 1 < LM) m_lcnt++;
        else begin
          forced = bg && b_lock;
          m_locked = 0;
          m_lcnt = 0;
        end
      end else if (bg && b_lock && !m_nore) begin
        m_locked = 1;
        m_lcnt = 1;
      end
      m_nore = forced || (m_nore && bg);
      e_av = own == 1 && !a_we;
      e_bv = own == 2 && !b_we;
      if (e_av) e_ad = rm[ix(a_addr)];
      if (e_bv) e_bd = rm[ix(b_addr)];
      if (own != 0 && ea[15] && ((own == 1 && a_we) || (own == 2 && b_we))) rm[ix(ea)] = ed;
    end
    #1;
  endtask
  task automatic reset_dut();
    rst = 1;
    cycle();
    rst = 0;
  endtask
  initial begin
    for (int i = 0; i < 64; i++) rm[i] = iv(6'(i));
    #1;
    a_req = 1; b_req = 1; b_lock = 1; a_we = 1; b_we = 1;
    a_addr = 16'h8001; b_addr = 16'h8003; a_wdata = 16'h1111; b_wdata = 16'h2222;
    cycle();
    check("rst_no_wen", obs_we, 0);
    check("rst_no_gnt", int'(obs_a | obs_b), 0);
    clr = 0;
    rst = 0;
    b_lock = 0;
    cycle();
    check("post_rst_a_first", obs_a, 1);
    reset_dut();
    b_req = 0; a_we = 1; a_addr = 16'h8002; a_wdata = 16'h1234;
    cycle();
    a_we = 0;
    cycle();
    a_req = 0;
    cycle();
    check("a_read_valid", obs_av, 1);
    check("a_read_data", obs_ad, 16'h1234);
    reset_dut();
    a_req = 1; a_we = 1; a_addr = 16'h8010; a_wdata = 16'h00AA;
    b_req = 1; b_we = 0; b_addr = 16'h8010;
    cycle();
    check("route_a_wins", obs_a, 1);
    a_req = 0;
    cycle();
    check("route_b_gnt", obs_b, 1);
    b_req = 0;
    cycle();
    check("route_b_data", obs_bd, 16'h00AA);
    a_req = 1; a_we = 1; a_addr = 16'h0004; a_wdata = 16'hFFFF;
    cycle();
    check("rom_wen_pulse", obs_we, 1);
    a_we = 0;
    cycle();
    a_req = 0;
    cycle();
    check("rom_unchanged", obs_ad, iv(ix(16'h0004)));
    reset_dut();
    a_req = 1; b_req = 1; a_we = 0; b_we = 0; b_lock = 0;
    for (int i = 0; i < 10; i++) begin
      cycle();
      check("contention_seq", obs_b, int'(i % 5 == 4));
    end
    reset_dut();
    b_lock = 1;
    for (int i = 0; i < 25; i++) begin
      cycle();
      check("lock_burst_seq", obs_b, int'((i >= 4 && i <= 19) || i == 24));
    end
    reset_dut();
    for (int i = 0; i < 9; i++) cycle();
    rst = 1;
    cycle();
    check("midlock_b_gnt", obs_b, 0);
    check("midlock_b_rvalid", obs_bv, 0);
    rst = 0;
    cycle();
    check("after_midlock_a", obs_a, 1);
    for (int n = 0; n < 3000; n++) begin
      if (rst) rst = 0;
      else if ($urandom_range(0, 399) == 0) rst = 1;
      if (!a_req || own == 1) begin
        a_req = $urandom_range(0, 2) != 0;
        a_we = 1'($urandom); a_addr = rnd_addr(); a_wdata = 16'($urandom);
      end else if ($urandom_range(0, 15) == 0) a_req = 0;
      if (!b_req || own == 2) begin
        b_req = $urandom_range(0, 5) != 0;
        b_we = 1'($urandom); b_addr = rnd_addr(); b_wdata = 16'($urandom);
      end else if ($urandom_range(0, 31) == 0) b_req = 0;
      if ($urandom_range(0, 24) == 0) b_lock = ~b_lock;
      cycle();
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Two-port arbiter that shares the single MMU access port between the CPU (port A) and a DMA/IO engine (port B). It issues one MMU access per cycle. A has default priority, B is protected against starvation, and B can lock the port for bursts up to a bounded length. It sits between the core/DMA and `MMU`, and drives `MMU`'s `w_en`/`addr`/`data_w` and consumes its `data_r`.

## Interface
- `MAX_WAIT`, default 4: cycles B may wait under contention before it wins (≥1).
- `LOCK_MAX`, default 16: maximum consecutive locked grants to B (≥2).
- `clk`  input  Clock  codebase clock bundle; all state updates on posedge `clk.ph0`.
- `rst`  input  1  reset, asynchronous, active-high.
- `a_req`, `a_we`  input  1  A access request / write enable.
- `a_addr`, `a_wdata`  input  16  A address / write data.
- `a_gnt`  output  1  A access performed this cycle (combinational).
- `a_rdata`  output  16  A read data (registered).
- `a_rvalid`  output  1  `a_rdata` valid, one-cycle pulse.
- `b_req`, `b_we`, `b_addr`, `b_wdata`, `b_gnt`, `b_rdata`, `b_rvalid`: as for A, port B.
- `b_lock`  input  1  B requests to keep ownership after its grant.
- `mmu_w_en`  output  1  MMU write enable.
- `mmu_addr`, `mmu_data_w`  output  16  MMU address / write data.
- `mmu_data_r`  input  16  MMU combinational read data.

## Operation
- **Requester handshake:**
  - Hold `req`, `we`, `addr` and `wdata` stable until `gnt` is sampled high at a `ph0` edge.
  - One access is made per grant.
  - Deasserting `req` before the grant withdraws the request with no side effects.
- **MMU drive:**
  - Owner's addr/wdata are muxed to the MMU.
  - `mmu_w_en = gnt_owner & we_owner`.
  - With no owner: `mmu_addr=0`, `mmu_data_w=0`, `mmu_w_en=0`.
  - The arbiter does not decode the ROM/RAM split; the MMU ignores writes with `addr[15]=0`.
- **State:**
  - `locked` (1 bit).
  - `wait_cnt` (saturating at `MAX_WAIT`).
  - `lock_cnt` (0..`LOCK_MAX`).
- **Owner select (combinational, first match wins):**
  1. `rst`: no owner.
  2. `locked & b_req`: B.
  3. `a_req & b_req`: B if `wait_cnt >= MAX_WAIT`, else A.
  4. `a_req` only: A. `b_req` only: B. Neither: none.
- **`wait_cnt` update:**
  - `b_req & !b_gnt`: +1, saturating.
  - `b_gnt` or `!b_req`: reset to 0.
- **Lock update:**
  - `locked` is set when `b_gnt & b_lock & !locked`; `lock_cnt` becomes 1.
  - While locked, each `b_gnt` with `b_lock` increments `lock_cnt`.
  - `locked` clears, with `lock_cnt` reset to 0, when any of these hold:
    - `!b_lock` at a `ph0` edge;
    - `!b_req`;
    - `lock_cnt` reaches `LOCK_MAX` at that edge.
  - After a forced release (`LOCK_MAX`), B cannot relock until a cycle in which B is not granted. A pending `a_req` therefore gets at least one grant.
  - A has no lock.
- **Read return:**
  - At each edge where X is granted and `!we`, `x_rdata <= mmu_data_r` and `x_rvalid <= 1`.
  - Otherwise `x_rvalid <= 0`; `x_rdata` holds its value.
  - Writes produce no `rvalid`.

## Timing
- Grant latency: `gnt` is asserted in the same cycle as `req` when the port wins; otherwise it waits.
- Write lands at the grant cycle's `ph0` edge.
- Read data arrives with `rvalid` exactly 1 cycle after the grant cycle.
- Back-to-back grants to the same port are allowed every cycle.
- Worst-case B wait with A requesting continuously: `MAX_WAIT` cycles, then a grant on the next cycle.
- Worst-case A wait: `LOCK_MAX` cycles.
- **Reset values (asynchronous):**
  - `a_gnt = b_gnt = 0`, `mmu_w_en = 0`, `mmu_addr = 0`, `mmu_data_w = 0`.
  - `a_rvalid = b_rvalid = 0`, `a_rdata = b_rdata = 0`.
  - `locked = 0`, `wait_cnt = 0`, `lock_cnt = 0`.
- **Reset mid-operation:**
  - Any in-flight `rvalid` is dropped.
  - Lock is released.
  - First post-reset cycle follows rule 3 with `wait_cnt = 0`.
- **Simultaneous events:**
  - `b_lock` falling in the same cycle as `lock_cnt` reaching `LOCK_MAX`: a single release.
  - `b_req` dropping while locked: release, with normal selection in that same cycle.

## Test plan
- **Reset:** assert `rst` with all requests high → all outputs 0, no MMU write. Deassert → A granted first.
- **A read:** RAM[0x8002] = 0x1234, `a_req=1`, `a_we=0`, `a_addr=0x8002` → `a_gnt=1` in the same cycle; next cycle `a_rvalid=1`, `a_rdata=0x1234`.
- **Contention:** `a_req` and `b_req` both held, `MAX_WAIT=4`, `b_lock=0` → grant sequence A,A,A,A,B repeating; `b_rvalid` pulses once per period.
- **Lock burst:** `LOCK_MAX=16`, B holds `b_lock=1`, A requesting → B receives 16 consecutive grants, A is granted on cycle 17, B is granted again after `wait_cnt` reaches 4.
- **Write routing:**
  - A writes 0x00AA to 0x8010 while B reads 0x8010 in the same cycle → A wins the write; B's read returns 0x00AA one cycle after B's grant.
  - Write to 0x0004 → `mmu_w_en` pulses; ROM is unchanged.
- **Reset mid-lock:** B locked at `lock_cnt=5`, assert `rst` → `locked=0`, `b_rvalid=0`, no grants. After release with both requesting → A is granted.
